// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-read-port integer register file.
package regfile_pkg;

    // Clear-sequencer states: sweeping zeros into storage, or open for writes.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int NREAD_MAX     = 4;

    // Default-width data word, for code that works at the core's native XLEN.
    typedef logic [XLEN_DEFAULT-1:0] rf_word_t;

    // Flattened width of a read-port bundle (NREAD ports of XLEN bits each).
    function automatic int read_bundle_bits(input int nread, input int xlen);
        return nread * xlen;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: sweeps zeros into registers 1..NREGS-1 after reset or on
// request, then opens the write port.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEFAULT,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_req,
    output logic          ready,
    output logic          busy,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_idx
);

    rf_state_e     state;
    logic [AW-1:0] clear_idx;

    // State, sweep index and registered ready flag; the index stops at the
    // last register rather than wrapping.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            clear_idx <= AW'(1);
            ready     <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clear_idx == AW'(NREGS - 1)) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        clear_idx <= clear_idx + 1'b1;
                    end
                end
                READY: begin
                    if (clear_req) begin
                        state     <= CLEAR;
                        clear_idx <= AW'(1);
                        ready     <= 1'b0;
                    end
                end
                default: begin
                    state     <= CLEAR;
                    clear_idx <= AW'(1);
                    ready     <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = ~ready;
    assign sweep_we  = ~ready;
    assign sweep_idx = clear_idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file: NREAD combinational read ports, one
// write port with optional write-to-read bypass, hardwired-zero register 0.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREGS  = NREGS_DEFAULT,
    parameter  int NREAD  = 2,
    parameter  bit BYPASS = 1'b1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREAD-1:0][AW-1:0]   reg_select,
    output logic [NREAD-1:0][XLEN-1:0] reg_out,
    input  logic [AW-1:0]              reg_write_select,
    input  logic [XLEN-1:0]            reg_write_data,
    input  logic                       reg_write_control,
    output logic                       reg_write_ready,
    input  logic                       clear_req,
    output logic                       busy
);

    logic [XLEN-1:0] registers [NREGS-1:1];
    logic            sweep_we;
    logic [AW-1:0]   sweep_idx;
    logic            write_accept;

    regfile_clear_fsm #(
        .NREGS (NREGS)
    ) u_clear_fsm (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .ready     (reg_write_ready),
        .busy      (busy),
        .sweep_we  (sweep_we),
        .sweep_idx (sweep_idx)
    );

    assign write_accept = reg_write_control && reg_write_ready;

    // Storage update: the clear sweep owns the array while busy, otherwise
    // the external port writes; index 0 writes are discarded.
    // NOTE: the array has no reset branch -- a reset fan-out to every bit is
    // costly, and the clear sweep provides the zeroing instead.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            registers[sweep_idx] <= '0;
        end else if (write_accept && (reg_write_select != '0)) begin
            registers[reg_write_select] <= reg_write_data;
        end
    end

    // Combinational read ports with zero-while-busy, hardwired x0 and bypass.
    // NOTE: each output gets a default before the conditions so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        for (int p = 0; p < NREAD; p++) begin
            reg_out[p] = '0;
            if (!busy && (reg_select[p] != '0)) begin
                if (BYPASS && write_accept && (reg_write_select == reg_select[p])) begin
                    reg_out[p] = reg_write_data;
                end else begin
                    reg_out[p] = registers[reg_select[p]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: one bypassing and one non-bypassing
// instance share stimulus; a reference model feeds an expectation queue.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    typedef struct {
        string           tag;
        logic [XLEN-1:0] val;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic [NREAD-1:0][AW-1:0]   reg_select = '0;
    logic [NREAD-1:0][XLEN-1:0] reg_out;
    logic [NREAD-1:0][XLEN-1:0] reg_out_nb;
    logic [AW-1:0]              reg_write_select = '0;
    logic [XLEN-1:0]            reg_write_data = '0;
    logic                       reg_write_control = 1'b0;
    logic                       clear_req = 1'b0;
    logic                       reg_write_ready;
    logic                       busy;
    logic                       ready_nb;
    logic                       busy_nb;

    int              n_cmp = 0;
    int              n_bad = 0;
    exp_t            exp_q[$];
    logic [XLEN-1:0] model [NREGS];

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1'b1)) dut (
        .clk               (clk),
        .reset             (reset),
        .reg_select        (reg_select),
        .reg_out           (reg_out),
        .reg_write_select  (reg_write_select),
        .reg_write_data    (reg_write_data),
        .reg_write_control (reg_write_control),
        .reg_write_ready   (reg_write_ready),
        .clear_req         (clear_req),
        .busy              (busy)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1'b0)) dut_nb (
        .clk               (clk),
        .reset             (reset),
        .reg_select        (reg_select),
        .reg_out           (reg_out_nb),
        .reg_write_select  (reg_write_select),
        .reg_write_data    (reg_write_data),
        .reg_write_control (reg_write_control),
        .reg_write_ready   (ready_nb),
        .clear_req         (clear_req),
        .busy              (busy_nb)
    );

    task automatic push_exp(input string tag, input logic [XLEN-1:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    // Single write from a negedge, accepted on the following posedge.
    task automatic drive_write(input logic [AW-1:0] idx, input logic [XLEN-1:0] data);
        @(negedge clk);
        reg_write_select  = idx;
        reg_write_data    = data;
        reg_write_control = 1'b1;
        @(posedge clk);
        #1;
        reg_write_control = 1'b0;
        if (idx != '0) model[idx] = data;
    endtask

    task automatic test_reset();
        exp_t e;
        int   cycles;
        @(negedge clk);
        reg_select[0] = 5'd5;
        reg_select[1] = 5'd31;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || reg_write_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: busy=%b ready=%b, required busy=1 ready=0", busy, reg_write_ready);
        end
        push_exp("reset_out0", '0);
        push_exp("reset_out1", '0);
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out[0] !== e.val) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, reg_out[0], e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out[1] !== e.val) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, reg_out[1], e.val); end

        @(negedge clk);
        reset = 1'b0;
        cycles = 0;
        while (!reg_write_ready && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 30) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy_edge30: busy=%b required 1", busy); end
            end
        end
        n_cmp++;
        if (cycles != 31 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_latency: edges=%0d busy=%b, required 31 edges busy=0", cycles, busy);
        end
        model_clear();

        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            reg_select[0] = AW'(i);
            reg_select[1] = AW'(NREGS - 1 - i);
            push_exp("reset_sweep_p0", model[i]);
            push_exp("reset_sweep_p1", model[NREGS-1-i]);
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (reg_out[0] !== e.val) begin n_bad++; $display("FAIL %s[x%0d]: got %h required %h", e.tag, i, reg_out[0], e.val); end
            e = exp_q.pop_front(); n_cmp++;
            if (reg_out[1] !== e.val) begin n_bad++; $display("FAIL %s[x%0d]: got %h required %h", e.tag, NREGS-1-i, reg_out[1], e.val); end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        @(negedge clk);
        reg_select[0]     = 5'd5;
        reg_select[1]     = 5'd5;
        reg_write_select  = 5'd5;
        reg_write_data    = 32'hDEADBEEF;
        reg_write_control = 1'b1;
        push_exp("bypass_same_cycle", 32'hDEADBEEF);
        push_exp("nobypass_same_cycle", model[5]);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out[0] !== e.val || reg_out[1] !== e.val) begin
            n_bad++; $display("FAIL %s: got %h/%h required %h", e.tag, reg_out[0], reg_out[1], e.val);
        end
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out_nb[0] !== e.val || reg_out_nb[1] !== e.val) begin
            n_bad++; $display("FAIL %s: got %h/%h required %h", e.tag, reg_out_nb[0], reg_out_nb[1], e.val);
        end
        @(posedge clk);
        model[5] = 32'hDEADBEEF;
        #1;
        reg_write_control = 1'b0;
        @(negedge clk);
        push_exp("write_read_next_bypass", model[5]);
        push_exp("write_read_next_nobypass", model[5]);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out[0] !== e.val || reg_out[1] !== e.val) begin
            n_bad++; $display("FAIL %s: got %h/%h required %h", e.tag, reg_out[0], reg_out[1], e.val);
        end
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out_nb[0] !== e.val || reg_out_nb[1] !== e.val) begin
            n_bad++; $display("FAIL %s: got %h/%h required %h", e.tag, reg_out_nb[0], reg_out_nb[1], e.val);
        end
    endtask

    task automatic test_x0();
        exp_t e;
        @(negedge clk);
        reg_select[0]     = 5'd0;
        reg_select[1]     = 5'd0;
        reg_write_select  = 5'd0;
        reg_write_data    = 32'hFFFFFFFF;
        reg_write_control = 1'b1;
        push_exp("x0_bypass_blocked", '0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out[0] !== e.val || reg_out[1] !== e.val) begin
            n_bad++; $display("FAIL %s: got %h/%h required %h", e.tag, reg_out[0], reg_out[1], e.val);
        end
        @(posedge clk);
        #1;
        reg_write_control = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            reg_select[0] = AW'(i);
            reg_select[1] = AW'(NREGS - 1 - i);
            push_exp("x0_sweep_p0", model[i]);
            push_exp("x0_sweep_p1", model[NREGS-1-i]);
            push_exp("x0_sweep_nb_p0", model[i]);
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (reg_out[0] !== e.val) begin n_bad++; $display("FAIL %s[x%0d]: got %h required %h", e.tag, i, reg_out[0], e.val); end
            e = exp_q.pop_front(); n_cmp++;
            if (reg_out[1] !== e.val) begin n_bad++; $display("FAIL %s[x%0d]: got %h required %h", e.tag, NREGS-1-i, reg_out[1], e.val); end
            e = exp_q.pop_front(); n_cmp++;
            if (reg_out_nb[0] !== e.val) begin n_bad++; $display("FAIL %s[x%0d]: got %h required %h", e.tag, i, reg_out_nb[0], e.val); end
        end
    endtask

    task automatic test_write_during_clear();
        exp_t e;
        int   cycles;
        // Single-cycle write while sweeping is dropped.
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL clear_req_busy: busy=%b required 1", busy); end
        reg_select[0]     = 5'd7;
        reg_select[1]     = 5'd7;
        reg_write_select  = 5'd7;
        reg_write_data    = 32'h00001234;
        reg_write_control = 1'b1;
        @(posedge clk);
        #1;
        reg_write_control = 1'b0;
        cycles = 1;
        while (!reg_write_ready && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        n_cmp++;
        if (cycles != 31) begin n_bad++; $display("FAIL clear_req_latency: edges=%0d required 31", cycles); end
        model_clear();
        @(negedge clk);
        push_exp("dropped_write_x7", model[7]);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out[0] !== e.val || reg_out_nb[1] !== e.val) begin
            n_bad++; $display("FAIL %s: got %h/%h required %h", e.tag, reg_out[0], reg_out_nb[1], e.val);
        end

        // The same write held until ready commits on the edge after ready rises.
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req         = 1'b0;
        reg_write_control = 1'b1;
        cycles = 0;
        while (!reg_write_ready && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        n_cmp++;
        if (cycles != 31) begin n_bad++; $display("FAIL held_write_latency: edges=%0d required 31", cycles); end
        push_exp("held_write_bypass", 32'h00001234);
        push_exp("held_write_nobypass", model[7]);
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out[0] !== e.val) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, reg_out[0], e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out_nb[0] !== e.val) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, reg_out_nb[0], e.val); end
        @(posedge clk);
        model[7] = 32'h00001234;
        #1;
        reg_write_control = 1'b0;
        @(negedge clk);
        push_exp("held_write_commit", model[7]);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out[1] !== e.val || reg_out_nb[1] !== e.val) begin
            n_bad++; $display("FAIL %s: got %h/%h required %h", e.tag, reg_out[1], reg_out_nb[1], e.val);
        end
    endtask

    task automatic test_clear_req();
        exp_t e;
        int   cycles;
        for (int i = 1; i < NREGS; i++) drive_write(AW'(i), XLEN'(i));
        @(negedge clk);
        reg_select[0] = 5'd17;
        reg_select[1] = 5'd31;
        push_exp("fill_x17", model[17]);
        push_exp("fill_x31", model[31]);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out[0] !== e.val) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, reg_out[0], e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out_nb[1] !== e.val) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, reg_out_nb[1], e.val); end

        @(negedge clk);
        reg_select[0]     = 5'd3;
        reg_write_select  = 5'd3;
        reg_write_data    = 32'h000000AA;
        reg_write_control = 1'b1;
        clear_req         = 1'b1;
        push_exp("clear_req_write_bypass", 32'h000000AA);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (reg_out[0] !== e.val) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, reg_out[0], e.val); end
        @(posedge clk);
        #1;
        reg_write_control = 1'b0;
        clear_req         = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || reg_out[0] !== '0) begin
            n_bad++; $display("FAIL clear_sweep_start: busy=%b out=%h required busy=1 out=0", busy, reg_out[0]);
        end
        cycles = 0;
        while (!reg_write_ready && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        n_cmp++;
        if (cycles != 31) begin n_bad++; $display("FAIL clear_sweep_latency: edges=%0d required 31", cycles); end
        model_clear();
        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            reg_select[0] = AW'(i);
            reg_select[1] = AW'(NREGS - 1 - i);
            push_exp("cleared_p0", model[i]);
            push_exp("cleared_nb_p1", model[NREGS-1-i]);
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (reg_out[0] !== e.val) begin n_bad++; $display("FAIL %s[x%0d]: got %h required %h", e.tag, i, reg_out[0], e.val); end
            e = exp_q.pop_front(); n_cmp++;
            if (reg_out_nb[1] !== e.val) begin n_bad++; $display("FAIL %s[x%0d]: got %h required %h", e.tag, NREGS-1-i, reg_out_nb[1], e.val); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        exp_t e;
        int   cycles;
        drive_write(5'd2, 32'h00000022);
        drive_write(5'd20, 32'h00002020);
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        // After 11 more edges the sweep index sits at 12.
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || reg_write_ready !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_flags: busy=%b ready=%b required 1/0", busy, reg_write_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        cycles = 0;
        while (!reg_write_ready && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        n_cmp++;
        if (cycles != 31) begin n_bad++; $display("FAIL mid_reset_latency: edges=%0d required 31", cycles); end
        model_clear();
        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            reg_select[0] = AW'(i);
            reg_select[1] = AW'(NREGS - 1 - i);
            push_exp("mid_reset_p0", model[i]);
            push_exp("mid_reset_p1", model[NREGS-1-i]);
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (reg_out[0] !== e.val) begin n_bad++; $display("FAIL %s[x%0d]: got %h required %h", e.tag, i, reg_out[0], e.val); end
            e = exp_q.pop_front(); n_cmp++;
            if (reg_out[1] !== e.val) begin n_bad++; $display("FAIL %s[x%0d]: got %h required %h", e.tag, NREGS-1-i, reg_out[1], e.val); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_write_read();
        test_x0();
        test_write_during_clear();
        test_clear_req();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
